// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1, LSB first, idle-high line.
//   Optional feature macro UART_RX_PARITY_EN: frames become 8E1 and even
//   parity is checked. Without it parity_err is tied to 0.
// Ports:
//   clk          system clock
//   res_n        asynchronous active-low reset
//   rx           serial line, asynchronous to clk, idles high
//   data_out     received byte, stable while data_valid is high
//   data_valid   byte available, held until accepted
//   data_ready   consumer accepts data_out at a clk edge while data_valid is high
//   busy         high in every state except IDLE
//   framing_err  one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch (0 without the macro)
//   overrun      one-cycle pulse: frame completed while holding register full
module uart_rx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 921600,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic                  framing_err,
   output logic                  parity_err,
   output logic                  overrun
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   generate
      if (DIV < 4) begin : g_div_chk
         $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
`ifdef UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t                state, state_n;
   logic                  s1, s2;
   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         idx, idx_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic [DATA_WIDTH-1:0] data_out_n;
   logic                  data_valid_n, ferr_n, ovr_n;
   logic                  bit_end;
`ifdef UART_RX_PARITY_EN
   logic                  par_bad, par_bad_n, perr_n;
`endif

   assign busy    = (state != IDLE);
   assign bit_end = (cnt == CNT_BIT);

   // two-flop synchronizer; reset to the idle level so reset cannot fake a start bit
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         data_out    <= data_out_n;
         data_valid  <= data_valid_n;
         framing_err <= ferr_n;
         overrun     <= ovr_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= par_bad_n;
         parity_err <= perr_n;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      idx_n        = idx;
      shreg_n      = shreg;
      data_out_n   = data_out;
      // an accept with no new byte empties the holding register
      data_valid_n = data_valid & ~data_ready;
      ferr_n       = 1'b0;
      ovr_n        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n    = par_bad;
      perr_n       = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!s2) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            // half a bit in: a line back high means a glitch, not a start bit
            if (cnt == CNT_HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = s2 ? IDLE : DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shreg_n = {s2, shreg[DATA_WIDTH-1:1]};
               idx_n   = idx + IW'(1);
               if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_n     = '0;
               par_bad_n = ^{shreg, s2};
               state_n   = STOP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               if (!s2) begin
                  // framing takes priority over parity; BREAK keeps a held-low line from re-triggering
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end else begin
                  state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) perr_n = 1'b1;
                  else
`endif
                  if (!data_valid || data_ready) begin
                     data_out_n   = shreg;
                     data_valid_n = 1'b1;
                  end else begin
                     ovr_n = 1'b1;
                  end
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         BREAK: begin
            if (s2) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIV=16, HALF=8.
module tb_uart_rx;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int DIV      = 16;
   localparam int HALF     = 8;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int K_DATA = 0, K_OVR = 1, K_FERR = 2, K_PERR = 3;

   logic       clk = 1'b0, res_n = 1'b0, rx = 1'b1, data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, busy, framing_err, parity_err, overrun;
   logic       dv_prev = 1'b0;
   int         checks = 0, failures = 0, cyc = 0;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_WIDTH(8)) dut (
      .clk(clk), .res_n(res_n), .rx(rx), .data_out(data_out),
      .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
      .framing_err(framing_err), .parity_err(parity_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic got_event(input int kind, input logic [7:0] d);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event: kind %0d data %h at cycle %0d, nothing expected", kind, d, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == K_DATA && e.data !== d) || e.cyc != cyc) begin
            failures++;
            $display("FAIL event: got kind %0d data %h cycle %0d, expected kind %0d data %h cycle %0d",
                     kind, d, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   // monitor: every output event is popped against the scoreboard
   always @(negedge clk) begin
      if (res_n) begin
         if (data_valid && !dv_prev) got_event(K_DATA, data_out);
         if (overrun) got_event(K_OVR, 8'h00);
         if (framing_err) got_event(K_FERR, 8'h00);
         if (parity_err) got_event(K_PERR, 8'h00);
      end
      dv_prev <= data_valid;
   end

   task automatic bit_time(input logic v);
      rx = v;
      repeat (DIV) @(posedge clk);
      #1;
   endtask

   // called at posedge+1; the next edge is E0
   task automatic send(input logic [7:0] d, input logic stop, input logic par_flip, input int kind);
      exp_t e;
      e.kind = kind;
      e.data = d;
      e.cyc  = cyc + 1 + 2 + HALF + 9 * DIV + (PAR ? DIV : 0);
      exp_q.push_back(e);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (PAR) bit_time(^d ^ par_flip);
      bit_time(stop);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_out", data_out, 0);
      chk("reset_valid", data_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_pulses", {framing_err, parity_err, overrun}, 0);
      res_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // single byte, consumer always ready
      data_ready = 1'b1;
      send(8'hA5, 1'b1, 1'b0, K_DATA);
      chk("a5_valid_dropped", data_valid, 0);
      chk("a5_busy_idle", busy, 0);

      // holding register full: second and third frames overrun
      data_ready = 1'b0;
      send(8'h31, 1'b1, 1'b0, K_DATA);
      send(8'h32, 1'b1, 1'b0, K_OVR);
      send(8'h33, 1'b1, 1'b0, K_OVR);
      chk("ovr_data_kept", data_out, 8'h31);
      chk("ovr_valid_held", data_valid, 1);
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      data_ready = 1'b0;
      chk("ovr_drained", data_valid, 0);
      repeat (4) @(posedge clk);
      #1;

      // bad stop bit then line held low
      send(8'h5C, 1'b0, 1'b0, K_FERR);
      repeat (40 * DIV) @(posedge clk);
      #1;
      chk("break_busy", busy, 1);
      chk("break_no_valid", data_valid, 0);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("break_released", busy, 0);

      // 5-cycle glitch: START gives up at cnt==7, i.e. edge E0+2+HALF
      e0 = cyc + 1;
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (e0 + 1 + HALF - cyc) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy_before_abort", busy, 1);
      @(negedge clk);
      chk("glitch_abort_cycle", busy, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_no_outputs", {data_valid, framing_err, parity_err, overrun}, 0);

      // reset in the middle of data bit 4 of a second frame
      send(8'h11, 1'b1, 1'b0, K_DATA);
      chk("pre_reset_valid", data_valid, 1);
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'(8'h22 >> i));
      rx = 1'b0;
      repeat (HALF) @(posedge clk);
      #2;
      res_n = 1'b0;
      #1;
      chk("midreset_valid", data_valid, 0);
      chk("midreset_data", data_out, 0);
      chk("midreset_busy", busy, 0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      res_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      data_ready = 1'b1;
      send(8'h5A, 1'b1, 1'b0, K_DATA);

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0, K_DATA);
      send(8'h07, 1'b1, 1'b1, K_PERR);
      chk("perr_no_valid", data_valid, 0);
`endif

      repeat (20) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive counterpart of the existing UART transmitter (8N1 line format, LSB first, idle-high line). It turns a serial `rx` pin into parallel bytes with a valid/ready handshake, so a host or debug link can push characters into the SoC, for example toward the controller or a ring buffer. It sits at the top level next to the UART transmit path and uses the same `clk` and synchronized `res_n`.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 921600: line rate in bit/s.
- `DATA_WIDTH`, default 8: data bits per frame.
- Derived values:
  - DIV = CLK_FREQ/BAUD, truncated.
  - HALF = DIV/2, truncated.
  - DIV must be at least 4, enforced by an elaboration-time `$error`.

- `clk`  in  1  system clock.
- `res_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line; asynchronous to `clk`; idles high.
- `data_out`  out  DATA_WIDTH  received byte; stable while `data_valid` is high.
- `data_valid`  out  1  byte available; held until it is accepted.
- `data_ready`  in  1  consumer accepts `data_out` at a clk edge while `data_valid` is high.
- `busy`  out  1  high in every state except IDLE.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).
- `overrun`  out  1  one-cycle pulse: a frame completed while the holding register was full.

## Operation
- Input synchronizer: 2-flop chain `rx` → s1 → s2. Both flops reset to 1. All decisions use s2.
- One counter, `cnt`, wide enough for DIV-1. One bit index, wide enough for DATA_WIDTH-1. One shift register, filled LSB first.
- States:
  - IDLE: when s2==0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt==HALF-1, sample s2.
    - s2 is 0: go to DATA with cnt=0, idx=0.
    - s2 is 1: glitch; go to IDLE, no error flagged.
  - DATA: at cnt==DIV-1, shift s2 in, set cnt=0, idx++. After bit DATA_WIDTH-1, go to PARITY if enabled, otherwise STOP.
  - PARITY (macro only): at cnt==DIV-1, check even parity over data plus the parity bit, then go to STOP.
  - STOP: at cnt==DIV-1, sample s2.
    - s2 is 1 and parity is OK: deliver the byte, go to IDLE.
    - s2 is 0: pulse `framing_err`, discard the byte, go to BREAK.
    - Parity bad: pulse `parity_err`, discard the byte, go to IDLE.
  - BREAK: wait for s2==1, then go to IDLE. This stops a held-low line from re-triggering.
- Sampling lands at mid-bit: HALF cycles into the start bit, then every DIV cycles.
- Delivery:
  - Holding register empty (`data_valid`=0), or being accepted in the same cycle (`data_ready`=1): load `data_out`, set `data_valid`=1.
  - Otherwise: pulse `overrun`, drop the new byte, keep the stored one.
- Accept without a new byte: `data_valid` goes to 0 at the next edge.
- If `framing_err` and `parity_err` both apply, only `framing_err` is reported.
- Asserting `res_n` at any point, including mid-frame, returns the block to IDLE. The partial byte is lost.

## Timing
- Reset values:
  - `data_out`=0, `data_valid`=0, `busy`=0.
  - `framing_err`=0, `parity_err`=0, `overrun`=0.
  - s1=s2=1, state=IDLE, cnt=0, idx=0.
- Let E0 be the first clk edge at which s1 captures `rx`=0.
  - STATE=START from E0+2.
  - `data_valid` rises at E0+2+HALF+(DATA_WIDTH+1)·DIV.
  - With parity enabled, add DIV.
- Error and overrun pulses occur at the same edge where `data_valid` would have risen.
- The next start bit is detected as early as the cycle after the STOP sample. This gives a half-bit margin for back-to-back frames.
- Baud tolerance: up to ±(HALF-1)/DIV accumulated per frame, about 4% total at DIV=16.

## Configuration
- `UART_RX_PARITY_EN`, defined: frames are 8E1. The PARITY state is present and even parity is checked.
- Not defined:
  - No PARITY state.
  - `parity_err` is tied to 0.
  - The port list stays identical.

## Test plan
All scenarios use CLK_FREQ=1_600_000 and BAUD=100_000, giving DIV=16 and HALF=8. Macro off unless stated.

- Byte 0xA5 sent with `data_ready`=1 → `data_out`=0xA5; `data_valid` rises at E0+154 and stays high one cycle; no error pulses.
- Frames 0x31 then 0x32 sent with `data_ready`=0 throughout, then a third frame 0x33 → `data_out`=0x31 after the first frame; `overrun` pulses at the end of frames 2 and 3; `data_out` stays 0x31.
- Stop bit driven 0, then the line held low 40 bit-times → one `framing_err` pulse; `data_valid` stays 0; `busy` stays 1 until `rx` returns high; no further frames are decoded.
- A 5-cycle low glitch on an idle line → START aborts at cnt==7; `busy` returns to 0; no outputs change.
- `res_n` pulsed low in the middle of data bit 4 → all outputs return to 0 immediately; the next clean frame 0x5A is received correctly.
- Macro on: 0x07 sent with parity bit 1 → `data_out`=0x07, `data_valid`=1. 0x07 sent with parity bit 0 → `parity_err` pulses, no `data_valid`.
